// File: rtl/lan_bus_arbiter.sv
// Two-requester arbiter and strobe sequencer for the W5300 16-bit host bus.
// Define LAN_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins) instead of round-robin.
module lan_bus_arbiter #(
   parameter int unsigned T_SETUP  = 5,
   parameter int unsigned T_STROBE = 5,
   parameter int unsigned T_HOLD   = 5
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_req0,
   input  logic        i_wr0,
   input  logic [9:0]  i_addr0,
   input  logic [15:0] i_wdata0,
   input  logic        i_lock0,
   output logic        o_ack0,
   input  logic        i_req1,
   input  logic        i_wr1,
   input  logic [9:0]  i_addr1,
   input  logic [15:0] i_wdata1,
   input  logic        i_lock1,
   output logic        o_ack1,
   output logic [15:0] o_rdata,
   output logic        o_busy,
   output logic [9:0]  o_lan_addr,
   inout  wire  [15:0] io_lan_data,
   output logic        o_lan_cs,
   output logic        o_lan_rd,
   output logic        o_lan_wr
);

   localparam int unsigned CW = 8;
   localparam logic [CW-1:0] SETUP_LD  = CW'(T_SETUP - 1);
   localparam logic [CW-1:0] STROBE_LD = CW'(T_STROBE - 1);
   localparam logic [CW-1:0] HOLD_LD   = CW'(T_HOLD - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_DONE
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_id;
   logic          r_wr;
   logic [9:0]    r_lan_addr;
   logic [15:0]   r_wdata;
   logic          r_oe;
   logic          r_cs;
   logic          r_rd;
   logic          r_wrs;
   logic          r_ack0;
   logic          r_ack1;
   logic [15:0]   r_rdata;
   logic          r_busy;
   logic          r_lock_act;
   logic          r_lock_id;

   logic          w_ok0;
   logic          w_ok1;
   logic          w_grant;
   logic          w_gnt_id;

   // A held lock masks out the other requester entirely
   assign w_ok0   = i_req0 && (!r_lock_act || !r_lock_id);
   assign w_ok1   = i_req1 && (!r_lock_act ||  r_lock_id);
   assign w_grant = w_ok0 || w_ok1;

`ifdef LAN_ARB_FIXED_PRIO_EN
   assign w_gnt_id = !w_ok0;
`else
   logic r_last;
   // r_last resets to 1 so requester 0 wins the first contention
   assign w_gnt_id = (w_ok0 && w_ok1) ? !r_last : w_ok1;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_last <= 1'b1;
      end else if (r_state == S_IDLE && w_grant) begin
         r_last <= w_gnt_id;
      end
   end
`endif

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_id       <= 1'b0;
         r_wr       <= 1'b0;
         r_lan_addr <= '0;
         r_wdata    <= '0;
         r_oe       <= 1'b0;
         r_cs       <= 1'b1;
         r_rd       <= 1'b1;
         r_wrs      <= 1'b1;
         r_ack0     <= 1'b0;
         r_ack1     <= 1'b0;
         r_rdata    <= '0;
         r_busy     <= 1'b0;
         r_lock_act <= 1'b0;
         r_lock_id  <= 1'b0;
      end else begin
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_id       <= w_gnt_id;
                  r_wr       <= w_gnt_id ? i_wr1    : i_wr0;
                  r_lan_addr <= w_gnt_id ? i_addr1  : i_addr0;
                  r_wdata    <= w_gnt_id ? i_wdata1 : i_wdata0;
                  r_oe       <= w_gnt_id ? i_wr1    : i_wr0;
                  r_cnt      <= SETUP_LD;
                  r_busy     <= 1'b1;
                  r_state    <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (r_cnt == '0) begin
                  r_cnt   <= STROBE_LD;
                  r_cs    <= 1'b0;
                  r_wrs   <= !r_wr;
                  r_rd    <= r_wr;
                  r_state <= S_STROBE;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_STROBE: begin
               if (r_cnt == '0) begin
                  // Capture on the edge that ends the strobe, while Rd is still low
                  if (!r_wr) r_rdata <= io_lan_data;
                  r_cnt   <= HOLD_LD;
                  r_cs    <= 1'b1;
                  r_wrs   <= 1'b1;
                  r_rd    <= 1'b1;
                  r_state <= S_HOLD;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_HOLD: begin
               if (r_cnt == '0) begin
                  r_oe    <= 1'b0;
                  r_ack0  <= !r_id;
                  r_ack1  <= r_id;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_DONE: begin
               r_lock_act <= r_id ? i_lock1 : i_lock0;
               r_lock_id  <= r_id;
               r_busy     <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign io_lan_data = r_oe ? r_wdata : {16{1'bz}};
   assign o_lan_addr  = r_lan_addr;
   assign o_lan_cs    = r_cs;
   assign o_lan_rd    = r_rd;
   assign o_lan_wr    = r_wrs;
   assign o_ack0      = r_ack0;
   assign o_ack1      = r_ack1;
   assign o_rdata     = r_rdata;
   assign o_busy      = r_busy;

endmodule
